carry_resolver: RTL

CARRY_RESOLVER -- requirements
Module: carry_resolver

---
 rtl/carry_resolver_pkg.sv | 22 ++
 rtl/carry_resolver.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/carry_resolver_pkg.sv
// Shared encoder constants for the carry resolver: default widths, FSM encoding
// and the fill bits used to build the pending-run bytes (all ones before a carry,
// all zeros after one).
package carry_resolver_pkg;

  localparam int DEF_OUT_WIDTH = 8;
  localparam int DEF_CNT_WIDTH = 8;

  // Fill bit of a run byte while the run is still unresolved (0xFF) and after a
  // carry has rippled through it (0x00).
  localparam logic FILL_PENDING = 1'b1;
  localparam logic FILL_CARRIED = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_HOLD      = 3'd1,
    ST_EMIT_HELD = 3'd2,
    ST_EMIT_RUN  = 3'd3,
    ST_FLUSH_END = 3'd4
  } state_t;

endpackage

// File: rtl/carry_resolver.sv
// Resolves arithmetic-coder carries: holds one byte plus a run of 0xFF bytes until a carry (or its absence) is known.
// Latency: an accepted precarry that resolves output shows out_valid on the next cycle; 0x0FF inputs only grow the run.
// Backpressure: out_ready low freezes out_byte/out_valid; in_ready is high only in IDLE and HOLD.
module carry_resolver
  import carry_resolver_pkg::*;
#(
  parameter int OUT_WIDTH = DEF_OUT_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [OUT_WIDTH:0]   in_precarry,
  input  logic                 in_flush,
  output logic                 in_ready,
  output logic [OUT_WIDTH-1:0] out_byte,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 out_error
);

  localparam logic [OUT_WIDTH-1:0] BYTE_RUN_FF = {OUT_WIDTH{FILL_PENDING}};
  localparam logic [OUT_WIDTH-1:0] BYTE_RUN_00 = {OUT_WIDTH{FILL_CARRIED}};
  localparam logic [OUT_WIDTH-1:0] BYTE_ONE    = OUT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] RUN_ONE     = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] RUN_TWO     = CNT_WIDTH'(2);
  localparam logic [CNT_WIDTH-1:0] RUN_MAX     = '1;

  state_t                 r_state, w_state_nxt;
  logic [OUT_WIDTH-1:0]   r_held, w_held_nxt;
  logic [OUT_WIDTH-1:0]   r_next, w_next_nxt;
  logic [CNT_WIDTH-1:0]   r_run, w_run_nxt;
  logic [OUT_WIDTH-1:0]   r_run_byte, w_run_byte_nxt;
  logic [OUT_WIDTH-1:0]   r_out_byte, w_out_byte_nxt;
  logic                   r_out_vld, w_out_vld_nxt;
  logic                   r_out_last, w_out_last_nxt;
  logic                   r_err, w_err_nxt;
  logic                   r_flush, w_flush_nxt;           // draining toward IDLE
  logic                   r_drain_next, w_drain_next_nxt; // next byte still owed at end of drain
  logic                   r_rdy_en;                       // keeps in_ready low until the first clock after reset
  logic                   w_done;

  logic                   w_carry;
  logic [OUT_WIDTH-1:0]   w_byte;
  logic                   w_in_rdy, w_take_vld, w_take_fls, w_hs, w_is_run, w_run_sat;
  logic [CNT_WIDTH-1:0]   w_run_inc;

  assign w_carry    = in_precarry[OUT_WIDTH];
  assign w_byte     = in_precarry[OUT_WIDTH-1:0];
  assign w_in_rdy   = r_rdy_en && (r_state == ST_IDLE || r_state == ST_HOLD);
  assign w_take_vld = w_in_rdy && in_valid;
  assign w_take_fls = w_in_rdy && in_flush;
  assign w_hs       = r_out_vld && out_ready;
  assign w_is_run   = w_take_vld && !w_carry && (w_byte == BYTE_RUN_FF);
  assign w_run_sat  = (r_run == RUN_MAX);
  assign w_run_inc  = w_run_sat ? r_run : r_run + RUN_ONE;

  assign in_ready  = w_in_rdy;
  assign out_byte  = r_out_byte;
  assign out_valid = r_out_vld;
  assign out_last  = r_out_last;
  assign out_error = r_err;

  // Next-state and next-register values for the resolver FSM.
  always_comb begin
    w_state_nxt      = r_state;
    w_held_nxt       = r_held;
    w_next_nxt       = r_next;
    w_run_nxt        = r_run;
    w_run_byte_nxt   = r_run_byte;
    w_out_byte_nxt   = r_out_byte;
    w_out_vld_nxt    = r_out_vld;
    w_out_last_nxt   = r_out_last;
    w_err_nxt        = r_err;
    w_flush_nxt      = r_flush;
    w_drain_next_nxt = r_drain_next;
    w_done           = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_take_vld) begin
          // A carry with nothing held has nowhere to go: flag it, keep the byte.
          w_held_nxt = w_byte;
          w_run_nxt  = '0;
          if (w_carry) w_err_nxt = 1'b1;
          if (w_take_fls) begin
            w_out_byte_nxt   = w_byte;
            w_out_vld_nxt    = 1'b1;
            w_out_last_nxt   = 1'b1;
            w_run_byte_nxt   = BYTE_RUN_FF;
            w_flush_nxt      = 1'b1;
            w_drain_next_nxt = 1'b0;
            w_state_nxt      = ST_EMIT_HELD;
          end else begin
            w_state_nxt = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (w_is_run) begin
          w_run_nxt = w_run_inc;
          if (w_run_sat) w_err_nxt = 1'b1;
          if (w_take_fls) begin
            w_out_byte_nxt   = r_held;
            w_out_vld_nxt    = 1'b1;
            w_out_last_nxt   = 1'b0;
            w_run_byte_nxt   = BYTE_RUN_FF;
            w_flush_nxt      = 1'b1;
            w_drain_next_nxt = 1'b0;
            w_state_nxt      = ST_EMIT_HELD;
          end
        end else if (w_take_vld) begin
          // Carry known: the held byte and the whole run resolve together.
          w_out_byte_nxt   = w_carry ? r_held + BYTE_ONE : r_held;
          w_run_byte_nxt   = w_carry ? BYTE_RUN_00 : BYTE_RUN_FF;
          w_next_nxt       = w_byte;
          w_out_vld_nxt    = 1'b1;
          w_out_last_nxt   = 1'b0;
          w_flush_nxt      = w_take_fls;
          w_drain_next_nxt = w_take_fls;
          w_state_nxt      = ST_EMIT_HELD;
        end else if (w_take_fls) begin
          w_out_byte_nxt   = r_held;
          w_out_vld_nxt    = 1'b1;
          w_out_last_nxt   = (r_run == '0);
          w_run_byte_nxt   = BYTE_RUN_FF;
          w_flush_nxt      = 1'b1;
          w_drain_next_nxt = 1'b0;
          w_state_nxt      = ST_EMIT_HELD;
        end
      end
      ST_EMIT_HELD: begin
        if (w_hs) begin
          if (r_run != '0) begin
            w_out_byte_nxt = r_run_byte;
            w_out_last_nxt = r_flush && !r_drain_next && (r_run == RUN_ONE);
            w_state_nxt    = ST_EMIT_RUN;
          end else begin
            w_done = 1'b1;
          end
        end
      end
      ST_EMIT_RUN: begin
        if (w_hs) begin
          w_run_nxt = r_run - RUN_ONE;
          if (r_run == RUN_ONE) w_done = 1'b1;
          else w_out_last_nxt = r_flush && !r_drain_next && (r_run == RUN_TWO);
        end
      end
      ST_FLUSH_END: begin
        if (w_hs) begin
          w_out_vld_nxt    = 1'b0;
          w_out_last_nxt   = 1'b0;
          w_flush_nxt      = 1'b0;
          w_drain_next_nxt = 1'b0;
          w_state_nxt      = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Held byte and run fully emitted: continue the drain or hold the next byte.
    if (w_done) begin
      if (r_flush && r_drain_next) begin
        w_out_byte_nxt = r_next;
        w_out_vld_nxt  = 1'b1;
        w_out_last_nxt = 1'b1;
        w_state_nxt    = ST_FLUSH_END;
      end else if (r_flush) begin
        w_out_vld_nxt  = 1'b0;
        w_out_last_nxt = 1'b0;
        w_flush_nxt    = 1'b0;
        w_state_nxt    = ST_IDLE;
      end else begin
        w_held_nxt     = r_next;
        w_out_vld_nxt  = 1'b0;
        w_out_last_nxt = 1'b0;
        w_state_nxt    = ST_HOLD;
      end
    end
  end

  // State, counter and output registers; reset discards anything in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_held       <= '0;
      r_next       <= '0;
      r_run        <= '0;
      r_run_byte   <= '0;
      r_out_byte   <= '0;
      r_out_vld    <= 1'b0;
      r_out_last   <= 1'b0;
      r_err        <= 1'b0;
      r_flush      <= 1'b0;
      r_drain_next <= 1'b0;
      r_rdy_en     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_held       <= w_held_nxt;
      r_next       <= w_next_nxt;
      r_run        <= w_run_nxt;
      r_run_byte   <= w_run_byte_nxt;
      r_out_byte   <= w_out_byte_nxt;
      r_out_vld    <= w_out_vld_nxt;
      r_out_last   <= w_out_last_nxt;
      r_err        <= w_err_nxt;
      r_flush      <= w_flush_nxt;
      r_drain_next <= w_drain_next_nxt;
      r_rdy_en     <= 1'b1;
    end
  end

endmodule
